// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine back-end: change width,
// coin values (in nickels), dispenser FSM states and small helpers.
package vend_pkg;

  localparam int unsigned CHG_W = 3;

  localparam logic [CHG_W-1:0] NICKEL     = 3'd1;
  localparam logic [CHG_W-1:0] DIME       = 3'd2;
  localparam logic [CHG_W-1:0] MAX_CHANGE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SODA_REQ,
    ST_SODA_REL,
    ST_COIN_SEL,
    ST_COIN_REQ,
    ST_COIN_REL
  } disp_state_e;

  typedef enum logic {
    COIN_NICKEL,
    COIN_DIME
  } coin_e;

  function automatic logic [CHG_W-1:0] sat_change(input logic [CHG_W-1:0] c);
    return (c > MAX_CHANGE) ? MAX_CHANGE : c;
  endfunction

  function automatic logic [CHG_W-1:0] coin_value(input coin_e c);
    return (c == COIN_DIME) ? DIME : NICKEL;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle of the vend strobe, hopper/motor handshakes and status flags.
// master = coin FSM / hopper side, slave = change_dispenser.
interface change_dispenser_if;
  import vend_pkg::*;

  logic             soda_i;
  logic [CHG_W-1:0] change_i;
  logic             soda_ack_i;
  logic             dime_ack_i;
  logic             nickel_ack_i;
  logic             dime_empty_i;
  logic             nickel_empty_i;
  logic             soda_req_o;
  logic             dime_req_o;
  logic             nickel_req_o;
  logic             busy_o;
  logic             ovf_o;
  logic             err_o;

  modport master (
    output soda_i, change_i, soda_ack_i, dime_ack_i, nickel_ack_i,
           dime_empty_i, nickel_empty_i,
    input  soda_req_o, dime_req_o, nickel_req_o, busy_o, ovf_o, err_o
  );

  modport slave (
    input  soda_i, change_i, soda_ack_i, dime_ack_i, nickel_ack_i,
           dime_empty_i, nickel_empty_i,
    output soda_req_o, dime_req_o, nickel_req_o, busy_o, ovf_o, err_o
  );

endinterface

// File: rtl/vend_req_fifo.sv
// Small synchronous FIFO of pending vend requests (change owed per vend).
// Pointers carry an extra wrap bit to tell full from empty.
module vend_req_fifo
  import vend_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = CHG_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Vending back-end: queues vend strobes and pays soda plus change through
// 4-phase req/ack handshakes, dimes first, nickels as fallback.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  change_dispenser_if.slave   bus
);

  disp_state_e      state_q, state_d;
  coin_e            coin_q, coin_d;
  logic [CHG_W-1:0] owed_q, owed_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             soda_req_q, soda_req_d;
  logic             dime_req_q, dime_req_d;
  logic             nickel_req_q, nickel_req_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CHG_W-1:0] fifo_dout;
  logic             coin_ack;

  vend_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CHG_W)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (bus.soda_i),
    .pop    (fifo_pop),
    .din    (sat_change(bus.change_i)),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Only the selected hopper's ack advances the handshake.
  assign coin_ack = (coin_q == COIN_DIME) ? bus.dime_ack_i : bus.nickel_ack_i;

  always_comb begin
    state_d  = state_q;
    coin_d   = coin_q;
    owed_d   = owed_q;
    err_d    = err_q;
    ovf_d    = ovf_q | (bus.soda_i & fifo_full);
    fifo_pop = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          owed_d   = fifo_dout;
          state_d  = ST_SODA_REQ;
        end
      end
      ST_SODA_REQ: begin
        if (bus.soda_ack_i) state_d = ST_SODA_REL;
      end
      ST_SODA_REL: begin
        if (!bus.soda_ack_i) state_d = ST_COIN_SEL;
      end
      ST_COIN_SEL: begin
        if (owed_q == '0) begin
          state_d = ST_IDLE;
        end else if ((owed_q >= DIME) && !bus.dime_empty_i) begin
          coin_d  = COIN_DIME;
          state_d = ST_COIN_REQ;
        end else if (!bus.nickel_empty_i) begin
          coin_d  = COIN_NICKEL;
          state_d = ST_COIN_REQ;
        end else begin
          err_d   = 1'b1;
          owed_d  = '0;
          state_d = ST_IDLE;
        end
      end
      ST_COIN_REQ: begin
        if (coin_ack) begin
          owed_d  = owed_q - coin_value(coin_q);
          state_d = ST_COIN_REL;
        end
      end
      ST_COIN_REL: begin
        if (!coin_ack) state_d = ST_COIN_SEL;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reqs are registered copies of the next-state decode, so they rise on
    // entry to a REQ state and fall the cycle after the ack is seen.
    soda_req_d   = (state_d == ST_SODA_REQ);
    dime_req_d   = (state_d == ST_COIN_REQ) && (coin_d == COIN_DIME);
    nickel_req_d = (state_d == ST_COIN_REQ) && (coin_d == COIN_NICKEL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      coin_q       <= COIN_NICKEL;
      owed_q       <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      soda_req_q   <= 1'b0;
      dime_req_q   <= 1'b0;
      nickel_req_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      coin_q       <= coin_d;
      owed_q       <= owed_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      soda_req_q   <= soda_req_d;
      dime_req_q   <= dime_req_d;
      nickel_req_q <= nickel_req_d;
    end
  end

  assign bus.soda_req_o   = soda_req_q;
  assign bus.dime_req_o   = dime_req_q;
  assign bus.nickel_req_o = nickel_req_q;
  assign bus.busy_o       = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.ovf_o        = ovf_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: expected req events are queued
// with each strobe and matched against observed req rising edges.
module tb_change_dispenser;

  localparam int EV_SODA   = 0;
  localparam int EV_DIME   = 1;
  localparam int EV_NICKEL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ack_en = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  change_dispenser_if bus ();

  change_dispenser #(.DEPTH(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Hopper/motor model: ack mirrors req half a cycle later when enabled.
  initial begin
    bus.soda_ack_i   = 1'b0;
    bus.dime_ack_i   = 1'b0;
    bus.nickel_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.soda_ack_i   = ack_en & bus.soda_req_o;
      bus.dime_ack_i   = ack_en & bus.dime_req_o;
      bus.nickel_ack_i = ack_en & bus.nickel_req_o;
    end
  end

  // Monitor: one-hot reqs and in-order match of req rises to the scoreboard.
  initial begin
    logic [2:0] prev, cur, rise;
    int got, exp;
    prev = '0;
    forever begin
      @(negedge clk);
      cur  = {bus.soda_req_o, bus.dime_req_o, bus.nickel_req_o};
      rise = cur & ~prev;
      vectors++;
      if ($countones(cur) > 1) begin
        miscompares++;
        $display("FAIL req_onehot: reqs=%b required at most one high", cur);
      end
      for (int b = 2; b >= 0; b--) begin
        if (rise[b]) begin
          got = (b == 2) ? EV_SODA : (b == 1) ? EV_DIME : EV_NICKEL;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL req_order: unexpected event %0d, none required", got);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              miscompares++;
              $display("FAIL req_order: event %0d, required %0d", got, exp);
            end
          end
        end
      end
      prev = cur;
    end
  end

  task automatic apply_reset();
    bus.soda_i = 1'b0;
    bus.change_i = '0;
    bus.dime_empty_i = 1'b0;
    bus.nickel_empty_i = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic strobe(input logic [2:0] c);
    @(posedge clk); #1;
    bus.soda_i = 1'b1;
    bus.change_i = c;
    @(posedge clk); #1;
    bus.soda_i = 1'b0;
    bus.change_i = '0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy_o) done = 1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s_idle_timeout: busy_o=%b, required 0", name, bus.busy_o);
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL %s_drained: %0d events pending, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_flags(input string name, input logic ovf, input logic err);
    vectors++;
    if (bus.ovf_o !== ovf) begin
      miscompares++;
      $display("FAIL %s_ovf: ovf_o=%b, required %b", name, bus.ovf_o, ovf);
    end
    vectors++;
    if (bus.err_o !== err) begin
      miscompares++;
      $display("FAIL %s_err: err_o=%b, required %b", name, bus.err_o, err);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({bus.soda_req_o, bus.dime_req_o, bus.nickel_req_o, bus.busy_o} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: req/busy=%b, required 0000",
               {bus.soda_req_o, bus.dime_req_o, bus.nickel_req_o, bus.busy_o});
    end
    check_flags("reset", 1'b0, 1'b0);
  endtask

  task automatic test_zero_change();
    exp_q.push_back(EV_SODA);
    strobe(3'd0);
    @(negedge clk);
    vectors++;
    if (bus.busy_o !== 1'b1 || bus.soda_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_t1: busy=%b soda_req=%b, required 1 0", bus.busy_o, bus.soda_req_o);
    end
    @(negedge clk);
    vectors++;
    if (bus.soda_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_t2: soda_req=%b, required 1", bus.soda_req_o);
    end
    wait_idle("zero");
    check_flags("zero", 1'b0, 1'b0);
  endtask

  task automatic test_change4();
    exp_q.push_back(EV_SODA);
    exp_q.push_back(EV_DIME);
    exp_q.push_back(EV_DIME);
    strobe(3'd4);
    wait_idle("chg4");
    check_flags("chg4", 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    exp_q.push_back(EV_SODA);
    exp_q.push_back(EV_DIME);
    exp_q.push_back(EV_DIME);
    strobe(3'd7);
    wait_idle("sat");
    check_flags("sat", 1'b0, 1'b0);
  endtask

  task automatic test_nickel_only();
    bus.dime_empty_i = 1'b1;
    exp_q.push_back(EV_SODA);
    repeat (3) exp_q.push_back(EV_NICKEL);
    strobe(3'd3);
    wait_idle("nick");
    check_flags("nick", 1'b0, 1'b0);
    bus.dime_empty_i = 1'b0;
  endtask

  task automatic test_no_coins();
    bus.dime_empty_i = 1'b1;
    bus.nickel_empty_i = 1'b1;
    exp_q.push_back(EV_SODA);
    strobe(3'd3);
    wait_idle("nocoin");
    check_flags("nocoin", 1'b0, 1'b1);
    bus.dime_empty_i = 1'b0;
    bus.nickel_empty_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    ack_en = 1'b0;
    exp_q.push_back(EV_SODA); exp_q.push_back(EV_NICKEL);
    exp_q.push_back(EV_SODA); exp_q.push_back(EV_DIME);
    exp_q.push_back(EV_SODA); exp_q.push_back(EV_DIME); exp_q.push_back(EV_DIME);
    @(posedge clk); #1;
    bus.soda_i = 1'b1; bus.change_i = 3'd1;
    @(posedge clk); #1; bus.change_i = 3'd2;
    @(posedge clk); #1; bus.change_i = 3'd4;
    @(posedge clk); #1; bus.change_i = 3'd3;
    @(posedge clk); #1; bus.soda_i = 1'b0; bus.change_i = '0;
    repeat (3) @(negedge clk);
    check_flags("b2b_held", 1'b1, 1'b0);
    ack_en = 1'b1;
    wait_idle("b2b");
    check_flags("b2b", 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    exp_q.push_back(EV_SODA);
    exp_q.push_back(EV_DIME);
    strobe(3'd2);
    strobe(3'd2);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.dime_req_o) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rstmid_dime_req: dime_req_o never rose, required 1");
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.soda_req_o, bus.dime_req_o, bus.nickel_req_o, bus.busy_o,
         bus.ovf_o, bus.err_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL rstmid_async: outputs=%b, required 000000",
               {bus.soda_req_o, bus.dime_req_o, bus.nickel_req_o, bus.busy_o,
                bus.ovf_o, bus.err_o});
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL rstmid_events: %0d events pending, required 0", exp_q.size());
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (bus.busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_busy: busy_o=%b, required 0", bus.busy_o);
    end
    check_flags("rstmid", 1'b0, 1'b0);
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_zero_change();
    test_change4();
    test_saturate();
    test_nickel_only();
    test_no_coins();
    apply_reset();
    test_reset();
    test_back_to_back();
    apply_reset();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
